// File: rtl/mips_cpu_bus_core.sv
// Multicycle MIPS-I subset CPU with one Avalon-MM style master port shared by
// instruction fetch and data access. GPR $2 is exported as register_v0.
module mips_cpu_bus_core (
   input  logic        clk,
   input  logic        reset,
   output logic        active,
   output logic [31:0] register_v0,
   output logic [31:0] address,
   output logic        write,
   output logic        read,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata
);
   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                          OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                          OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23,
                          OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                          F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_MFHI = 6'h10,
                          F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13, F_MULT = 6'h18,
                          F_MULTU = 6'h19, F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24,
                          F_OR = 6'h25, F_XOR = 6'h26, F_SLT = 6'h2A, F_SLTU = 6'h2B;

   typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;

   state_t      state, state_next;
   logic        running;
   logic [31:0] pc, ir, hi, lo, ea, mdr;
   logic [31:0] regs [32];

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [31:0] rs_val, rt_val, imm_s, imm_z, pc_plus4;

   assign opcode   = ir[31:26];
   assign rs       = ir[25:21];
   assign rt       = ir[20:16];
   assign rd       = ir[15:11];
   assign shamt    = ir[10:6];
   assign funct    = ir[5:0];
   assign imm      = ir[15:0];
   assign rs_val   = regs[rs];
   assign rt_val   = regs[rt];
   assign imm_s    = {{16{imm[15]}}, imm};
   assign imm_z    = {16'h0000, imm};
   assign pc_plus4 = pc + 32'd4;

   // Extending both operands to 64 bits makes one multiplier serve MULT and MULTU.
   logic        signed_mul;
   logic [63:0] mul_a, mul_b, product;
   assign signed_mul = ~funct[0];
   assign mul_a      = {{32{signed_mul & rs_val[31]}}, rs_val};
   assign mul_b      = {{32{signed_mul & rt_val[31]}}, rt_val};
   assign product    = mul_a * mul_b;

   logic        wb_en, hi_we, lo_we, is_load, is_store, is_jump, halt;
   logic [4:0]  wb_reg;
   logic [31:0] wb_val, pc_next, hi_val, lo_val;

   always_comb begin
      wb_en    = 1'b0;
      wb_reg   = rd;
      wb_val   = 32'h0;
      pc_next  = pc_plus4;
      hi_we    = 1'b0;
      lo_we    = 1'b0;
      hi_val   = product[63:32];
      lo_val   = product[31:0];
      is_load  = 1'b0;
      is_store = 1'b0;
      is_jump  = 1'b0;
      case (opcode)
         OP_SPECIAL: begin
            wb_en = 1'b1;
            case (funct)
               F_SLL:   wb_val = rt_val << shamt;
               F_SRL:   wb_val = rt_val >> shamt;
               F_SRA:   wb_val = $unsigned($signed(rt_val) >>> shamt);
               F_SLLV:  wb_val = rt_val << rs_val[4:0];
               F_SRLV:  wb_val = rt_val >> rs_val[4:0];
               F_SRAV:  wb_val = $unsigned($signed(rt_val) >>> rs_val[4:0]);
               F_MFHI:  wb_val = hi;
               F_MFLO:  wb_val = lo;
               F_ADDU:  wb_val = rs_val + rt_val;
               F_SUBU:  wb_val = rs_val - rt_val;
               F_AND:   wb_val = rs_val & rt_val;
               F_OR:    wb_val = rs_val | rt_val;
               F_XOR:   wb_val = rs_val ^ rt_val;
               F_SLT:   wb_val = {31'd0, $signed(rs_val) < $signed(rt_val)};
               F_SLTU:  wb_val = {31'd0, rs_val < rt_val};
               F_JR:    begin wb_en = 1'b0; is_jump = 1'b1; pc_next = rs_val; end
               F_MTHI:  begin wb_en = 1'b0; hi_we = 1'b1; hi_val = rs_val; end
               F_MTLO:  begin wb_en = 1'b0; lo_we = 1'b1; lo_val = rs_val; end
               F_MULT, F_MULTU: begin wb_en = 1'b0; hi_we = 1'b1; lo_we = 1'b1; end
               default: wb_en = 1'b0;
            endcase
         end
         OP_J:   begin is_jump = 1'b1; pc_next = {pc_plus4[31:28], ir[25:0], 2'b00}; end
         OP_BEQ: begin
            is_jump = 1'b1;
            if (rs_val == rt_val) pc_next = pc_plus4 + (imm_s << 2);
         end
         OP_BNE: begin
            is_jump = 1'b1;
            if (rs_val != rt_val) pc_next = pc_plus4 + (imm_s << 2);
         end
         OP_ADDIU: begin wb_en = 1'b1; wb_reg = rt; wb_val = rs_val + imm_s; end
         OP_SLTI:  begin wb_en = 1'b1; wb_reg = rt; wb_val = {31'd0, $signed(rs_val) < $signed(imm_s)}; end
         OP_SLTIU: begin wb_en = 1'b1; wb_reg = rt; wb_val = {31'd0, rs_val < imm_s}; end
         OP_ANDI:  begin wb_en = 1'b1; wb_reg = rt; wb_val = rs_val & imm_z; end
         OP_ORI:   begin wb_en = 1'b1; wb_reg = rt; wb_val = rs_val | imm_z; end
         OP_XORI:  begin wb_en = 1'b1; wb_reg = rt; wb_val = rs_val ^ imm_z; end
         OP_LUI:   begin wb_en = 1'b1; wb_reg = rt; wb_val = {imm, 16'h0000}; end
         OP_LW:    is_load = 1'b1;
         OP_SB, OP_SH, OP_SW: is_store = 1'b1;
         default: ;
      endcase
   end

   // A control transfer landing on address zero is the program's exit.
   assign halt = is_jump && (pc_next == 32'h0);

   // running holds the bus idle for the first cycle after reset is released.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH;
         running <= 1'b0;
         pc      <= RESET_VECTOR;
         ir      <= 32'h0;
         hi      <= 32'h0;
         lo      <= 32'h0;
         ea      <= 32'h0;
         mdr     <= 32'h0;
         for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      end else begin
         running <= 1'b1;
         state   <= state_next;
         case (state)
            FETCH: if (running && !waitrequest) ir <= readdata;
            EXEC: begin
               pc <= pc_next;
               ea <= rs_val + imm_s;
               if (hi_we) hi <= hi_val;
               if (lo_we) lo <= lo_val;
               if (wb_en && wb_reg != 5'd0) regs[wb_reg] <= wb_val;
            end
            MEM:  if (is_load && !waitrequest) mdr <= readdata;
            WB:   if (rt != 5'd0) regs[rt] <= mdr;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      read       = 1'b0;
      write      = 1'b0;
      address    = 32'h0;
      writedata  = 32'h0;
      byteenable = 4'b0000;
      case (state)
         FETCH: if (running) begin
            read       = 1'b1;
            address    = pc;
            byteenable = 4'b1111;
            if (!waitrequest) state_next = EXEC;
         end
         EXEC: begin
            if (halt)                     state_next = HALT;
            else if (is_load || is_store) state_next = MEM;
            else                          state_next = FETCH;
         end
         MEM: begin
            address = ea;
            if (is_load) begin
               read       = 1'b1;
               byteenable = 4'b1111;
            end else begin
               write = 1'b1;
               case (opcode)
                  OP_SB:   begin writedata = {24'h0, rt_val[7:0]};  byteenable = 4'b0001; end
                  OP_SH:   begin writedata = {16'h0, rt_val[15:0]}; byteenable = 4'b0011; end
                  default: begin writedata = rt_val;                byteenable = 4'b1111; end
               endcase
            end
            if (!waitrequest) state_next = is_load ? WB : FETCH;
         end
         WB:      state_next = FETCH;
         default: ;
      endcase
   end

   assign active      = running && (state != HALT);
   assign register_v0 = regs[2];
endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// Bench for mips_cpu_bus_core: a word memory model answers the bus, expected
// stores sit in a scoreboard queue, and each program ends with JR $0.
module tb_mips_cpu_bus_core;
   localparam logic [31:0] BOOT = 32'hBFC00000;
   localparam logic [31:0] NOP  = 32'h0;

   logic        clk, reset, active, write, read, waitrequest;
   logic [31:0] register_v0, address, writedata, readdata;
   logic [3:0]  byteenable;

   mips_cpu_bus_core dut (
      .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
      .address(address), .write(write), .read(read), .waitrequest(waitrequest),
      .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] op0;
      logic [31:0] op1;
      logic [31:0] res;
   } alu_vec_t;

   int          checks = 0;
   int          errors = 0;
   int          stall_fetch = 0;
   int          stall_write = 0;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] prog [$];
   wr_t         sb [$];
   alu_vec_t    vecs [$];
   logic [31:0] snap_addr, snap_wd;
   logic [3:0]  snap_be;
   logic        snap_rd, snap_wr;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
      return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
   endfunction

   function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
      return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   function automatic logic [31:0] enc_j(input int op, input logic [31:0] target);
      return {op[5:0], target[27:2]};
   endfunction

   function automatic wr_t exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_t w;
      w.addr = a;
      w.data = d;
      w.be   = be;
      return w;
   endfunction

   task automatic new_program();
      prog.delete();
      mem.delete();
      sb.delete();
   endtask

   task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] op0,
                          input logic [31:0] op1, input logic [31:0] res);
      alu_vec_t v;
      v.a = a; v.b = b; v.op0 = op0; v.op1 = op1; v.res = res;
      vecs.push_back(v);
   endtask

   // Slave model: decides waitrequest, supplies readdata, checks that a stalled
   // transfer holds still, and retires completed stores against the scoreboard.
   always @(negedge clk) begin
      logic stall;
      wr_t  e;
      stall = 1'b0;
      if (reset === 1'b1) begin
         waitrequest = 1'b0;
         readdata    = 32'h0;
      end else begin
         if (waitrequest) begin
            checkOutput("hold_address", address, snap_addr);
            checkOutput("hold_read", {31'd0, read}, {31'd0, snap_rd});
            checkOutput("hold_write", {31'd0, write}, {31'd0, snap_wr});
            checkOutput("hold_byteenable", {28'd0, byteenable}, {28'd0, snap_be});
            checkOutput("hold_writedata", writedata, snap_wd);
         end
         if (read === 1'b1 && address[31:28] == 4'hB && stall_fetch > 0) begin
            stall = 1'b1;
            stall_fetch--;
         end else if (write === 1'b1 && stall_write > 0) begin
            stall = 1'b1;
            stall_write--;
         end
         if (stall && !waitrequest) begin
            snap_addr = address; snap_rd = read; snap_wr = write;
            snap_be = byteenable; snap_wd = writedata;
         end
         waitrequest = stall;
         readdata    = (read === 1'b1) ? mem_read(address) : 32'h0;
         if (write === 1'b1 && !stall) begin
            checkOutput("rw_exclusive", {31'd0, read}, 32'd0);
            if (sb.size() == 0) begin
               checkOutput("unexpected_write", address, 32'hFFFFFFFF);
            end else begin
               e = sb.pop_front();
               checkOutput("wr_address", address, e.addr);
               checkOutput("wr_data", writedata, e.data);
               checkOutput("wr_byteenable", {28'd0, byteenable}, {28'd0, e.be});
            end
            for (int k = 0; k < 4; k++)
               if (byteenable[k]) begin
                  logic [31:0] w;
                  w = mem_read(address);
                  w[k*8 +: 8] = writedata[k*8 +: 8];
                  mem[address] = w;
               end
         end
      end
   end

   // Loads prog at the boot vector, resets, runs to halt and checks the result.
   task automatic applyStimulus(input string name, input int exp_cycles, input logic [31:0] exp_v0);
      int   cycles;
      bit   done;
      logic quiet;
      for (int i = 0; i < prog.size(); i++) mem[BOOT + 32'(i * 4)] = prog[i];
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      cycles = 0;
      done   = 1'b0;
      for (int n = 0; n < 3000 && !done; n++) begin
         @(negedge clk);
         if (active === 1'b1) cycles++;
         else if (cycles > 0) done = 1'b1;
      end
      if (!done) checkOutput({name, "_timeout"}, 32'd1, 32'd0);
      checkOutput({name, "_cycles"}, cycles, exp_cycles);
      checkOutput({name, "_v0"}, register_v0, exp_v0);
      checkOutput({name, "_sb_empty"}, sb.size(), 32'd0);
      quiet = 1'b0;
      repeat (20) begin
         @(negedge clk);
         quiet = quiet | read | write | active;
      end
      checkOutput({name, "_halt_quiet"}, {31'd0, quiet}, 32'd0);
      sb.delete();
   endtask

   initial begin
      reset       = 1'b1;
      waitrequest = 1'b0;
      readdata    = 32'h0;

      // Reset values, first fetch, then a reset that aborts a stalled fetch.
      new_program();
      @(negedge clk);
      checkOutput("rst_active", {31'd0, active}, 32'd0);
      checkOutput("rst_read", {31'd0, read}, 32'd0);
      checkOutput("rst_write", {31'd0, write}, 32'd0);
      checkOutput("rst_byteenable", {28'd0, byteenable}, 32'd0);
      checkOutput("rst_writedata", writedata, 32'd0);
      checkOutput("rst_v0", register_v0, 32'd0);
      stall_fetch = 50;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("first_read", {31'd0, read}, 32'd1);
      checkOutput("first_address", address, BOOT);
      checkOutput("first_byteenable", {28'd0, byteenable}, 32'hF);
      checkOutput("first_active", {31'd0, active}, 32'd1);
      repeat (2) @(negedge clk);
      checkOutput("abort_pre_read", {31'd0, read}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_read", {31'd0, read}, 32'd0);
      checkOutput("abort_active", {31'd0, active}, 32'd0);
      stall_fetch = 0;

      // Register-to-register operations: $1=a, $2=b, result in $3 stored to 200.
      add_vec(9, 5, enc_r(1, 2, 3, 0, 'h25), NOP, 13);
      add_vec(9, 5, enc_i('h0D, 1, 3, 5), NOP, 13);
      add_vec(9, 5, enc_r(0, 1, 3, 2, 'h00), NOP, 36);
      add_vec(9, 5, enc_r(1, 2, 3, 0, 'h2A), NOP, 0);
      add_vec(9, 5, enc_i('h0A, 1, 3, 15), NOP, 1);
      add_vec(9, 5, enc_i('h0B, 1, 3, 15), NOP, 1);
      add_vec(9, 5, enc_r(1, 2, 3, 0, 'h2B), NOP, 0);
      add_vec(9, 5, enc_r(0, 1, 3, 3, 'h03), NOP, 1);
      add_vec(9, 5, enc_r(0, 1, 3, 3, 'h02), NOP, 1);
      add_vec(9, 5, enc_r(2, 1, 3, 0, 'h07), NOP, 0);
      add_vec(9, 5, enc_r(2, 1, 3, 0, 'h06), NOP, 0);
      add_vec(9, 5, enc_r(1, 2, 3, 0, 'h23), NOP, 4);
      add_vec(9, 5, enc_r(1, 2, 3, 0, 'h26), NOP, 12);
      add_vec(9, 5, enc_i('h0E, 1, 3, 5), NOP, 12);
      add_vec(9, 5, enc_r(1, 2, 3, 0, 'h21), NOP, 14);
      add_vec(9, 5, enc_r(1, 2, 3, 0, 'h24), NOP, 1);
      add_vec(32'hFFFF0009, 5, enc_i('h0C, 1, 3, 'hFFFF), NOP, 32'h9);
      add_vec(9, 5, enc_i('h09, 1, 3, 'hFFFF), NOP, 8);
      add_vec(9, 5, enc_i('h0F, 0, 3, 'h1234), NOP, 32'h12340000);
      add_vec(32'h80000000, 5, enc_r(0, 1, 3, 4, 'h03), NOP, 32'hF8000000);
      add_vec(32'hFFFFFFFF, 1, enc_r(1, 2, 3, 0, 'h2A), NOP, 1);
      add_vec(32'hFFFFFFFF, 1, enc_r(1, 2, 3, 0, 'h2B), NOP, 0);
      add_vec(5, 0, enc_i('h0B, 1, 3, 'hFFFF), NOP, 1);
      add_vec(5, 0, enc_i('h0A, 1, 3, 'hFFFF), NOP, 0);
      add_vec(32'hFFFFFFFD, 7, enc_r(1, 2, 0, 0, 'h18), enc_r(0, 0, 3, 0, 'h10), 32'hFFFFFFFF);
      add_vec(32'hFFFFFFFD, 7, enc_r(1, 2, 0, 0, 'h19), enc_r(0, 0, 3, 0, 'h10), 32'h6);
      add_vec(32'hFFFFFFFD, 7, enc_r(1, 2, 0, 0, 'h18), enc_r(0, 0, 3, 0, 'h12), 32'hFFFFFFEB);
      add_vec(32'hDEADBEEF, 0, enc_r(1, 0, 0, 0, 'h13), enc_r(0, 0, 3, 0, 'h12), 32'hDEADBEEF);
      add_vec(32'h13579BDF, 0, enc_r(1, 0, 0, 0, 'h11), enc_r(0, 0, 3, 0, 'h10), 32'h13579BDF);
      add_vec(32'hF0, 4, enc_r(2, 1, 3, 0, 'h06), NOP, 32'h0F);
      add_vec(1, 31, enc_r(2, 1, 3, 0, 'h04), NOP, 32'h80000000);
      add_vec(32'h80000000, 31, enc_r(2, 1, 3, 0, 'h07), NOP, 32'hFFFFFFFF);
      add_vec(32'hFFFF0000, 0, enc_i('h0E, 1, 3, 'h8000), NOP, 32'hFFFF8000);
      add_vec(9, 5, enc_r(1, 2, 0, 0, 'h21), enc_r(0, 0, 3, 0, 'h25), 0);

      for (int i = 0; i < vecs.size(); i++) begin
         new_program();
         prog.push_back(enc_i('h0F, 0, 1, int'(vecs[i].a[31:16])));
         prog.push_back(enc_i('h0D, 1, 1, int'(vecs[i].a[15:0])));
         prog.push_back(enc_i('h0F, 0, 2, int'(vecs[i].b[31:16])));
         prog.push_back(enc_i('h0D, 2, 2, int'(vecs[i].b[15:0])));
         prog.push_back(vecs[i].op0);
         prog.push_back(vecs[i].op1);
         prog.push_back(enc_i('h2B, 0, 3, 200));
         prog.push_back(enc_r(0, 0, 0, 0, 'h08));
         sb.push_back(exp_wr(200, vecs[i].res, 4'b1111));
         applyStimulus($sformatf("alu%0d", i), 17, vecs[i].b);
      end

      // Loads feeding HI/LO and back out through stores.
      new_program();
      mem[100] = 123;
      mem[101] = 404;
      prog = '{enc_i('h23, 0, 1, 100), enc_r(1, 0, 0, 0, 'h11), enc_i('h23, 0, 1, 101),
               enc_r(1, 0, 0, 0, 'h13), enc_r(0, 0, 1, 0, 'h10), enc_i('h2B, 0, 1, 200),
               enc_r(0, 0, 1, 0, 'h12), enc_i('h2B, 0, 1, 201), enc_r(0, 0, 0, 0, 'h08)};
      sb.push_back(exp_wr(200, 123, 4'b1111));
      sb.push_back(exp_wr(201, 404, 4'b1111));
      applyStimulus("hilo_mem", 24, 0);

      // Loaded operands into MULT.
      new_program();
      mem[102] = 3;
      mem[103] = 4;
      prog = '{enc_i('h23, 0, 1, 102), enc_i('h23, 0, 2, 103), enc_r(1, 2, 0, 0, 'h18),
               enc_r(0, 0, 3, 0, 'h12), enc_i('h2B, 0, 3, 203), enc_r(0, 0, 0, 0, 'h08)};
      sb.push_back(exp_wr(203, 12, 4'b1111));
      applyStimulus("load_mult", 17, 4);

      // Sub-word stores, including upper bits that must be masked off.
      new_program();
      prog = '{enc_i('h09, 0, 1, 9), enc_i('h28, 0, 1, 206), enc_i('h29, 0, 1, 207),
               enc_i('h0F, 0, 1, 'hABCD), enc_i('h0D, 1, 1, 'h1289), enc_i('h28, 0, 1, 208),
               enc_i('h29, 0, 1, 209), enc_i('h2B, 0, 1, 210), enc_r(0, 0, 0, 0, 'h08)};
      sb.push_back(exp_wr(206, 32'h9, 4'b0001));
      sb.push_back(exp_wr(207, 32'h9, 4'b0011));
      sb.push_back(exp_wr(208, 32'h89, 4'b0001));
      sb.push_back(exp_wr(209, 32'h1289, 4'b0011));
      sb.push_back(exp_wr(210, 32'hABCD1289, 4'b1111));
      applyStimulus("subword", 23, 0);

      // Untaken BEQ, taken BNE, J over a skipped instruction.
      new_program();
      prog = '{enc_i('h09, 0, 1, 1), enc_i('h04, 1, 0, 1), enc_i('h09, 0, 2, 5),
               enc_i('h05, 1, 0, 1), enc_i('h09, 0, 2, 7), enc_j('h02, BOOT + 32'd28),
               enc_i('h09, 0, 2, 9), enc_i('h09, 2, 2, 1), enc_r(0, 0, 0, 0, 'h08)};
      applyStimulus("branch", 14, 6);

      // Three wait states on the first fetch and on the store.
      new_program();
      prog = '{enc_i('h09, 0, 1, 77), enc_i('h2B, 0, 1, 300), enc_r(0, 0, 0, 0, 'h08)};
      sb.push_back(exp_wr(300, 77, 4'b1111));
      stall_fetch = 3;
      stall_write = 3;
      applyStimulus("stall", 13, 0);
      checkOutput("stall_fetch_used", stall_fetch, 32'd0);
      checkOutput("stall_write_used", stall_write, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
